ic_link_pair_router: RTL and testbench

- Parametrised successor to the fixed two-pair TIA-568B link top level.
- Accepts word streams from PAIRS cable pairs, buffers each pair in its own FIFO, and routes any input pair to any output pair through a runtime route map. This replaces the hard-wired 12→36 / 54→78 redirects.
- Tracks per-pair activity with hysteresis (PairUp) and changes routes only after a drain, so no word is lost or duplicated.
- Sits between the post-LNA pair receivers and the downstream pair drivers.

---
 rtl/ic_link_pkg.sv | 35 +++
 rtl/ic_link_pair_fifo.sv | 58 +++++
 rtl/ic_link_pair_router.sv | 211 +++++++++++++++++++++
 tb/tb_ic_link_pair_router.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ic_link_pkg.sv
// Shared types and sizing helpers for the ic_link pair router.
package ic_link_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SWAP  = 2'd2
    } state_t;

    localparam int DEF_PAIRS     = 2;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_WINDOW    = 256;
    localparam int DEF_UP_THRESH = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) result++;
        end
        return result;
    endfunction

    // Route selector width; never zero so a single-pair build still elaborates.
    function automatic int sel_width(input int pairs);
        return (pairs > 1) ? clog2(pairs) : 1;
    endfunction

    // Width of a counter that must hold 0..limit inclusive.
    function automatic int cnt_width(input int limit);
        return clog2(limit + 1);
    endfunction

endpackage

// File: rtl/ic_link_pair_fifo.sv
// Single-clock WIDTH x DEPTH FIFO with synchronous flush, full/empty flags and occupancy count.
module ic_link_pair_fifo
    import ic_link_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int CW   = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && !empty;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: the storage array is deliberately not reset; count and the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/ic_link_pair_router.sv
// PAIRS-way word router: per-input FIFOs, runtime route map changed only after a drain, PairUp hysteresis.
// Define IC_LINK_DROP_DOWN_PAIR_EN to discard (but still count) words accepted while a pair is down.
module ic_link_pair_router
    import ic_link_pkg::*;
#(
    parameter int PAIRS     = DEF_PAIRS,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int WINDOW    = DEF_WINDOW,
    parameter int UP_THRESH = DEF_UP_THRESH,
    localparam int SELW     = sel_width(PAIRS)
) (
    input  logic                    Clock100Mhz,
    input  logic                    Reset,
    input  logic [PAIRS*WIDTH-1:0]  InData,
    input  logic [PAIRS-1:0]        InValid,
    output logic [PAIRS-1:0]        InReady,
    output logic [PAIRS*WIDTH-1:0]  OutData,
    output logic [PAIRS-1:0]        OutValid,
    input  logic [PAIRS-1:0]        OutReady,
    input  logic [PAIRS*SELW-1:0]   RouteSel,
    input  logic                    RouteLoad,
    output logic [PAIRS-1:0]        PairUp,
    output logic                    Busy
);

    localparam int CW = cnt_width(DEPTH);
    localparam int OW = CW + 1;
    localparam int WW = sel_width(WINDOW);
    localparam int TW = cnt_width(UP_THRESH);

    state_t state, state_nx;

    logic [PAIRS-1:0][WIDTH-1:0] in_words;
    logic [PAIRS-1:0][SELW-1:0]  route_sel;
    logic [PAIRS-1:0][SELW-1:0]  route_map;
    logic [PAIRS-1:0][SELW-1:0]  pending;

    logic [PAIRS-1:0]            in_ready_q;
    logic [PAIRS-1:0]            ready_nx;
    logic [PAIRS-1:0]            accept;
    logic [PAIRS-1:0]            keep;
    logic [PAIRS-1:0]            flush;
    logic [PAIRS-1:0]            referenced;
    logic [PAIRS-1:0][OW-1:0]    occ;

    logic [PAIRS-1:0]            stg_v;
    logic [PAIRS-1:0][WIDTH-1:0] stg_d;

    logic [PAIRS-1:0]            fifo_pop;
    logic [PAIRS-1:0]            fifo_full;
    logic [PAIRS-1:0]            fifo_empty;
    logic [PAIRS-1:0][CW-1:0]    fifo_count;
    logic [PAIRS-1:0][WIDTH-1:0] fifo_head;

    logic [PAIRS-1:0]            served;
    logic [PAIRS-1:0]            out_load;
    logic [PAIRS-1:0][WIDTH-1:0] load_data;
    logic [PAIRS-1:0]            out_v;
    logic [PAIRS-1:0][WIDTH-1:0] out_d;

    logic [WW-1:0]               win_cnt;
    logic                        wrap;
    logic [PAIRS-1:0][TW-1:0]    act_cnt;
    logic [PAIRS-1:0]            pair_up_q;
    logic                        drained;

    assign in_words  = InData;
    assign route_sel = RouteSel;
    assign accept    = InValid & in_ready_q;

`ifdef IC_LINK_DROP_DOWN_PAIR_EN
    assign keep = pair_up_q;
`else
    assign keep = '1;
`endif

    // Accepted words sit one cycle in a staging register before entering the FIFO.
    for (genvar p = 0; p < PAIRS; p++) begin : g_fifo
        ic_link_pair_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (Clock100Mhz),
            .rst   (Reset),
            .flush (flush[p]),
            .push  (stg_v[p]),
            .wdata (stg_d[p]),
            .pop   (fifo_pop[p]),
            .rdata (fifo_head[p]),
            .full  (fifo_full[p]),
            .empty (fifo_empty[p]),
            .count (fifo_count[p])
        );
    end

    // Only the lowest-index output mapped to a given input drains it.
    always_comb begin
        served = '1;
        for (int o = 1; o < PAIRS; o++) begin
            for (int j = 0; j < o; j++) begin
                if (route_map[j] == route_map[o]) served[o] = 1'b0;
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the loops; a path that skips an assignment would infer a latch.
        referenced = '0;
        out_load   = '0;
        fifo_pop   = '0;
        load_data  = '0;
        for (int o = 0; o < PAIRS; o++) begin
            for (int p = 0; p < PAIRS; p++) begin
                if (route_map[o] == SELW'(p)) begin
                    referenced[p] = 1'b1;
                    if (served[o] && !fifo_empty[p] && (!out_v[o] || OutReady[o])) begin
                        out_load[o]  = 1'b1;
                        fifo_pop[p]  = 1'b1;
                        load_data[o] = fifo_head[p];
                    end
                end
            end
        end
    end

    assign flush   = (state == IDLE && RouteLoad) ? ~referenced : '0;
    assign drained = (&fifo_empty) && !(|stg_v) && !(|out_v);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (RouteLoad) state_nx = DRAIN;
            DRAIN:   if (drained)   state_nx = SWAP;
            SWAP:                   state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clock100Mhz or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Ready ignores same-cycle pops, so it may lag a free slot by one cycle but never overfills.
    always_comb begin
        occ      = '0;
        ready_nx = '0;
        for (int p = 0; p < PAIRS; p++) begin
            occ[p]      = OW'(fifo_count[p]) + OW'(stg_v[p]) + OW'(accept[p] & keep[p]);
            ready_nx[p] = (state_nx == IDLE) && !fifo_full[p] && (occ[p] < OW'(DEPTH));
        end
    end

    always_ff @(posedge Clock100Mhz or posedge Reset) begin
        if (Reset) begin
            in_ready_q <= '1;
            stg_v      <= '0;
            stg_d      <= '0;
            out_v      <= '0;
            out_d      <= '0;
            pending    <= '0;
            for (int o = 0; o < PAIRS; o++) route_map[o] <= SELW'(o);
        end else begin
            in_ready_q <= ready_nx;
            stg_v      <= accept & keep & ~flush;
            for (int p = 0; p < PAIRS; p++) begin
                if (accept[p]) stg_d[p] <= in_words[p];
            end
            for (int o = 0; o < PAIRS; o++) begin
                if (out_load[o]) begin
                    out_v[o] <= 1'b1;
                    out_d[o] <= load_data[o];
                end else if (OutReady[o]) begin
                    out_v[o] <= 1'b0;
                end
            end
            if (state == IDLE && RouteLoad) pending   <= route_sel;
            if (state == SWAP)              route_map <= pending;
        end
    end

    assign wrap = (win_cnt == WW'(WINDOW - 1));

    // A word accepted on the wrap edge opens the new window's count.
    always_ff @(posedge Clock100Mhz or posedge Reset) begin
        if (Reset) begin
            win_cnt   <= '0;
            act_cnt   <= '0;
            pair_up_q <= '0;
        end else begin
            win_cnt <= wrap ? '0 : win_cnt + 1'b1;
            for (int p = 0; p < PAIRS; p++) begin
                if (wrap) begin
                    if (act_cnt[p] >= TW'(UP_THRESH))          pair_up_q[p] <= 1'b1;
                    else if (act_cnt[p] < TW'(UP_THRESH / 2))  pair_up_q[p] <= 1'b0;
                    act_cnt[p] <= accept[p] ? TW'(1) : '0;
                end else if (accept[p] && act_cnt[p] != TW'(UP_THRESH)) begin
                    act_cnt[p] <= act_cnt[p] + 1'b1;
                end
            end
        end
    end

    assign InReady  = in_ready_q;
    assign OutValid = out_v;
    assign OutData  = out_d;
    assign PairUp   = pair_up_q;
    assign Busy     = (state != IDLE);

endmodule

// File: tb/tb_ic_link_pair_router.sv
// Directed bench for ic_link_pair_router (PAIRS=2, WIDTH=8, DEPTH=4, WINDOW=16, UP_THRESH=4).
module tb_ic_link_pair_router;

    logic        clk;
    logic        Reset;
    logic [15:0] InData;
    logic [1:0]  InValid;
    logic [1:0]  InReady;
    logic [15:0] OutData;
    logic [1:0]  OutValid;
    logic [1:0]  OutReady;
    logic [1:0]  RouteSel;
    logic        RouteLoad;
    logic [1:0]  PairUp;
    logic        Busy;

    int errors = 0;
    int checks = 0;
    int edge_n;

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    ic_link_pair_router #(
        .PAIRS     (2),
        .WIDTH     (8),
        .DEPTH     (4),
        .WINDOW    (16),
        .UP_THRESH (4)
    ) dut (
        .Clock100Mhz (clk),
        .Reset       (Reset),
        .InData      (InData),
        .InValid     (InValid),
        .InReady     (InReady),
        .OutData     (OutData),
        .OutValid    (OutValid),
        .OutReady    (OutReady),
        .RouteSel    (RouteSel),
        .RouteLoad   (RouteLoad),
        .PairUp      (PairUp),
        .Busy        (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    always @(posedge clk or posedge Reset) begin
        if (Reset) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    // Records every transfer that the next rising edge will complete.
    always @(negedge clk) begin
        #1;
        if (!Reset) begin
            if (OutValid[0] && OutReady[0]) q0.push_back(OutData[7:0]);
            if (OutValid[1] && OutReady[1]) q1.push_back(OutData[15:8]);
        end
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] q0_at(input int i);
        return (i < q0.size()) ? q0[i] : 8'h00;
    endfunction

    function automatic logic [7:0] q1_at(input int i);
        return (i < q1.size()) ? q1[i] : 8'h00;
    endfunction

    task automatic clear_queues();
        q0.delete();
        q1.delete();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) @(negedge clk);
        Reset = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int p, input logic [7:0] d, input string tag);
        logic ok;
        ok = 1'b0;
        InValid[p] = 1'b1;
        InData[p*8 +: 8] = d;
        for (int n = 0; n < 50 && !ok; n++) begin
            ok = InReady[p];
            @(posedge clk);
            @(negedge clk);
        end
        InValid[p] = 1'b0;
        if (!ok) check({tag, "_accept"}, 32'(ok), 32'd1);
    endtask

    task automatic load_route(input logic [1:0] sel);
        RouteSel  = sel;
        RouteLoad = 1'b1;
        @(negedge clk);
        RouteLoad = 1'b0;
        RouteSel  = 2'b00;
    endtask

    task automatic wait_idle(input string tag);
        for (int n = 0; n < 60 && Busy; n++) @(negedge clk);
        check({tag, "_idle"}, 32'(Busy), 32'd0);
    endtask

    task automatic wait_edge(input int target);
        for (int n = 0; n < 200 && edge_n < target; n++) @(negedge clk);
    endtask

    initial begin
        Reset     = 1'b1;
        InData    = '0;
        InValid   = '0;
        OutReady  = 2'b11;
        RouteSel  = '0;
        RouteLoad = 1'b0;
        @(negedge clk);
        do_reset();

        check("rst_outvalid", 32'(OutValid), 32'h0);
        check("rst_outdata",  32'(OutData),  32'h0);
        check("rst_pairup",   32'(PairUp),   32'h0);
        check("rst_busy",     32'(Busy),     32'h0);

        // Identity route, two-edge latency.
        clear_queues();
        send(0, 8'h11, "id0");
        send(0, 8'h22, "id1");
        check("id_lat_v0",  32'(OutValid[0]), 32'd0);
        @(negedge clk);
        check("id_first_v", 32'(OutValid[0]), 32'd1);
        check("id_first_d", 32'(OutData[7:0]), 32'h11);
        @(negedge clk);
        check("id_second_d", 32'(OutData[7:0]), 32'h22);
        check("id_out1_idle", 32'(OutValid[1]), 32'd0);
        @(negedge clk);
        check("id_drained_v", 32'(OutValid[0]), 32'd0);
        check("id_q1_empty", 32'(q1.size()), 32'd0);

        // Backpressure: 4 FIFO words plus the output register.
        clear_queues();
        OutReady = 2'b10;
        for (int i = 0; i < 5; i++) send(0, 8'hA1 + 8'(i), "bp");
        repeat (3) @(negedge clk);
        check("bp_ready_low", 32'(InReady[0]), 32'd0);
        check("bp_hold_v",    32'(OutValid[0]), 32'd1);
        check("bp_hold_d",    32'(OutData[7:0]), 32'hA1);
        OutReady = 2'b11;
        repeat (15) @(negedge clk);
        check("bp_count", 32'(q0.size()), 32'd5);
        for (int i = 0; i < 5; i++) check("bp_order", 32'(q0_at(i)), 32'hA1 + 32'(i));
        check("bp_ready_back", 32'(InReady[0]), 32'd1);

        // Route swap with words in flight; a load during DRAIN is ignored.
        clear_queues();
        OutReady = 2'b10;
        send(0, 8'hB1, "sw");
        send(0, 8'hB2, "sw");
        repeat (3) @(negedge clk);
        load_route(2'b01);
        check("sw_busy",  32'(Busy),    32'd1);
        check("sw_ready", 32'(InReady), 32'h0);
        load_route(2'b11);
        check("sw_busy_hold", 32'(Busy), 32'd1);
        OutReady = 2'b11;
        wait_idle("sw");
        check("sw_drain_n",  32'(q0.size()), 32'd2);
        check("sw_drain_d0", 32'(q0_at(0)),  32'hB1);
        check("sw_drain_d1", 32'(q0_at(1)),  32'hB2);
        repeat (2) @(negedge clk);
        clear_queues();
        send(0, 8'hC1, "sw");
        send(1, 8'hD1, "sw");
        repeat (6) @(negedge clk);
        check("sw_p0_to_o1_n", 32'(q1.size()), 32'd1);
        check("sw_p0_to_o1_d", 32'(q1_at(0)),  32'hC1);
        check("sw_p1_to_o0_n", 32'(q0.size()), 32'd1);
        check("sw_p1_to_o0_d", 32'(q0_at(0)),  32'hD1);

        // Conflict route {0,0}, then flush of unreferenced pair1.
        load_route(2'b00);
        wait_idle("fl_a");
        repeat (2) @(negedge clk);
        clear_queues();
        for (int i = 0; i < 3; i++) send(1, 8'hE1 + 8'(i), "fl");
        send(0, 8'h5A, "fl");
        repeat (4) @(negedge clk);
        check("fl_conf_o0_n", 32'(q0.size()), 32'd1);
        check("fl_conf_o0_d", 32'(q0_at(0)),  32'h5A);
        check("fl_conf_o1_n", 32'(q1.size()), 32'd0);
        load_route(2'b10);
        wait_idle("fl_b");
        repeat (6) @(negedge clk);
        check("fl_none_o1", 32'(q1.size()), 32'd0);
        check("fl_none_o0", 32'(q0.size()), 32'd1);
        send(1, 8'hF1, "fl");
        repeat (6) @(negedge clk);
        check("fl_after_n", 32'(q1.size()), 32'd1);
        check("fl_after_d", 32'(q1_at(0)),  32'hF1);

        // Hysteresis over aligned windows; wraps land on edges 16, 32, 48, 64.
        do_reset();
        clear_queues();
        wait_edge(1);
        for (int i = 0; i < 5; i++) send(0, 8'h40 + 8'(i), "hy1");
        wait_edge(15);
        check("hy_before_wrap", 32'(PairUp), 32'h0);
        wait_edge(16);
        check("hy_w1_up", 32'(PairUp), 32'h1);
        wait_edge(18);
        for (int i = 0; i < 3; i++) send(0, 8'h50 + 8'(i), "hy2");
        wait_edge(32);
        check("hy_w2_hold", 32'(PairUp), 32'h1);
        wait_edge(34);
        send(0, 8'h60, "hy3");
        wait_edge(47);
        check("hy_w3_pre", 32'(PairUp), 32'h1);
        wait_edge(48);
        check("hy_w3_down", 32'(PairUp), 32'h0);
        wait_edge(50);
        for (int i = 0; i < 5; i++) send(0, 8'h70 + 8'(i), "hy4");
        wait_edge(64);
        check("hy_w4_up", 32'(PairUp), 32'h1);

        // Asynchronous reset in the middle of DRAIN.
        OutReady = 2'b00;
        send(0, 8'h31, "ar");
        send(0, 8'h32, "ar");
        repeat (3) @(negedge clk);
        load_route(2'b01);
        check("ar_busy_pre", 32'(Busy),        32'd1);
        check("ar_valid_pre", 32'(OutValid[0]), 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        check("ar_outvalid", 32'(OutValid), 32'h0);
        check("ar_outdata",  32'(OutData),  32'h0);
        check("ar_busy",     32'(Busy),     32'd0);
        check("ar_pairup",   32'(PairUp),   32'h0);
        @(negedge clk);
        Reset = 1'b0;
        OutReady = 2'b11;
        clear_queues();
        send(0, 8'h77, "ar");
        send(1, 8'h88, "ar");
        repeat (6) @(negedge clk);
        check("ar_map_o0_n", 32'(q0.size()), 32'd1);
        check("ar_map_o0_d", 32'(q0_at(0)),  32'h77);
        check("ar_map_o1_n", 32'(q1.size()), 32'd1);
        check("ar_map_o1_d", 32'(q1_at(0)),  32'h88);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
